// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped data-cache controller.
// Address layout (byte address): tag=[15:8], index=[7:3], offset=[2:0]; a line is 4 x 16-bit words.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL, ACC} state_t;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned OFF_W   = 3;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned WSEL_W  = 2;

  localparam int unsigned TAG_LSB  = 8;
  localparam int unsigned IDX_LSB  = 3;
  localparam int unsigned OFF_LSB  = 0;
  localparam int unsigned WSEL_LSB = 1;

  // Byte address of word w of the line {tag, idx}.
  function automatic logic [ADDR_W-1:0] lineWordAddr(input logic [TAG_W-1:0] tag,
                                                     input logic [IDX_W-1:0] idx,
                                                     input logic [WSEL_W-1:0] w);
    return {tag, idx, w, 1'b0};
  endfunction

endpackage

// File: rtl/dcache_ctrl_mem_ret_track.sv
// Memory-return tracker: a MEM_LAT-deep shift register of issue-valid bits.
// Ports: clk, rst (async active-high, clears in-flight reads), issue (a read was issued
// this cycle), ret_valid (the read issued MEM_LAT cycles ago returns this cycle).
module mem_ret_track #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic ret_valid
);

  logic [MEM_LAT-1:0] pipeValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid <= '0;
    end else begin
      pipeValid[0] <= issue;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipeValid[i] <= pipeValid[i-1];
      end
    end
  end

  assign ret_valid = pipeValid[MEM_LAT-1];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: turns a Rd/Wr request into a hit, or a miss handled by
// an optional dirty writeback (WB) and a 4-word line fill (FILL) followed by a replayed access (ACC).
// Ports: clk, rst (async active-high); upstream Addr/DataIn/Rd/Wr -> DataOut/Done/Stall/CacheHit;
// cache array c_* request outputs and c_hit/c_dirty/c_valid/c_tag_out/c_data_out responses;
// main memory mem_addr/mem_data_in/mem_wr/mem_rd, mem_data_out, mem_stall.
// Optional: define DCACHE_STATS_EN to add saturating req_count/hit_count outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              c_enable,
  output logic              c_comp,
  output logic              c_write,
  output logic [TAG_W-1:0]  c_tag,
  output logic [IDX_W-1:0]  c_index,
  output logic [OFF_W-1:0]  c_offset,
  output logic              c_valid_in,
  output logic [DATA_W-1:0] c_data_in,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [DATA_W-1:0] c_data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data_out,
`ifdef DCACHE_STATS_EN
  output logic [15:0]       req_count,
  output logic [15:0]       hit_count,
`endif
  input  logic              mem_stall
);

  state_t              state;
  logic [ADDR_W-1:0]   latAddr;
  logic [DATA_W-1:0]   latData;
  logic                latWr;
  logic [TAG_W-1:0]    victimTag;
  logic [WSEL_W-1:0]   wbCnt;
  logic [WSEL_W:0]     issueCnt;
  logic [WSEL_W-1:0]   fillCnt;
  logic                retValid;

  logic                req;
  logic                issueFire;
  logic [TAG_W-1:0]    latTag;
  logic [IDX_W-1:0]    latIdx;
  logic [WSEL_W-1:0]   latWord;

  assign req       = Rd | Wr;
  assign latTag    = latAddr[TAG_LSB +: TAG_W];
  assign latIdx    = latAddr[IDX_LSB +: IDX_W];
  assign latWord   = latAddr[WSEL_LSB +: WSEL_W];
  assign issueFire = (state == FILL) && (issueCnt < (WSEL_W+1)'(WORDS)) && !mem_stall;

  mem_ret_track #(.MEM_LAT(MEM_LAT)) u_ret (
    .clk       (clk),
    .rst       (rst),
    .issue     (issueFire),
    .ret_valid (retValid)
  );

  // State and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      latAddr   <= '0;
      latData   <= '0;
      latWr     <= 1'b0;
      victimTag <= '0;
      wbCnt     <= '0;
      issueCnt  <= '0;
      fillCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !c_hit) begin
            latAddr   <= Addr;
            latData   <= DataIn;
            latWr     <= Wr;
            victimTag <= c_tag_out;
            wbCnt     <= '0;
            issueCnt  <= '0;
            fillCnt   <= '0;
            state     <= (c_valid && c_dirty) ? WB : FILL;
          end
        end
        WB: begin
          // A stalled bank leaves wbCnt in place so the same word is re-issued.
          if (!mem_stall) begin
            wbCnt <= wbCnt + WSEL_W'(1);
            if (wbCnt == WSEL_W'(WORDS - 1)) state <= FILL;
          end
        end
        FILL: begin
          if (issueFire) issueCnt <= issueCnt + (WSEL_W+1)'(1);
          if (retValid) begin
            fillCnt <= fillCnt + WSEL_W'(1);
            if (fillCnt == WSEL_W'(WORDS - 1)) state <= ACC;
          end
        end
        ACC:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Upstream, cache-array and memory outputs; all forced to 0 while rst is high.
  always_comb begin
    DataOut     = '0;
    Done        = 1'b0;
    Stall       = 1'b0;
    CacheHit    = 1'b0;
    c_enable    = 1'b0;
    c_comp      = 1'b0;
    c_write     = 1'b0;
    c_tag       = '0;
    c_index     = '0;
    c_offset    = '0;
    c_valid_in  = 1'b0;
    c_data_in   = '0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            c_enable  = 1'b1;
            c_comp    = 1'b1;
            c_write   = Wr;
            c_tag     = Addr[TAG_LSB +: TAG_W];
            c_index   = Addr[IDX_LSB +: IDX_W];
            c_offset  = Addr[OFF_LSB +: OFF_W];
            c_data_in = DataIn;
            if (c_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = c_data_out;
            end else begin
              Stall = 1'b1;
            end
          end
        end
        WB: begin
          Stall       = 1'b1;
          c_enable    = 1'b1;
          c_tag       = victimTag;
          c_index     = latIdx;
          c_offset    = {wbCnt, 1'b0};
          mem_wr      = !mem_stall;
          mem_addr    = lineWordAddr(victimTag, latIdx, wbCnt);
          mem_data_in = c_data_out;
        end
        FILL: begin
          Stall = 1'b1;
          if (issueFire) begin
            mem_rd   = 1'b1;
            mem_addr = lineWordAddr(latTag, latIdx, issueCnt[WSEL_W-1:0]);
          end
          if (retValid) begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_tag      = latTag;
            c_index    = latIdx;
            c_offset   = {fillCnt, 1'b0};
            // The store's own word takes the store data so the line is never stale.
            c_data_in  = (latWr && (fillCnt == latWord)) ? latData : mem_data_out;
          end
        end
        ACC: begin
          c_enable  = 1'b1;
          c_comp    = 1'b1;
          c_write   = latWr;
          c_tag     = latTag;
          c_index   = latIdx;
          c_offset  = latAddr[OFF_LSB +: OFF_W];
          c_data_in = latData;
          Done      = 1'b1;
          DataOut   = c_data_out;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating request and hit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count <= '0;
      hit_count <= '0;
    end else if (state == IDLE && req) begin
      if (req_count != 16'hFFFF) req_count <= req_count + 16'd1;
      if (c_hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with behavioural cache array and 2-cycle-latency memory models.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit;
  logic        c_enable, c_comp, c_write, c_valid_in;
  logic [7:0]  c_tag, c_tag_out;
  logic [4:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data_in, c_data_out;
  logic        c_hit, c_dirty, c_valid;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_wr, mem_rd, mem_stall;
`ifdef DCACHE_STATS_EN
  logic [15:0] req_count, hit_count;
`endif

  int checks = 0;
  int failures = 0;
  int expReq = 0;
  int expHits = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
    .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_tag(c_tag),
    .c_index(c_index), .c_offset(c_offset), .c_valid_in(c_valid_in), .c_data_in(c_data_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data_out(mem_data_out),
`ifdef DCACHE_STATS_EN
    .req_count(req_count), .hit_count(hit_count),
`endif
    .mem_stall(mem_stall)
  );

  // Cache array model: per-word valid, per-line tag and dirty.
  logic [7:0]  cTag  [32];
  logic [3:0]  cVal  [32];
  logic        cDirty[32];
  logic [15:0] cData [32][4];

  assign c_hit      = (cTag[c_index] == c_tag) && cVal[c_index][c_offset[2:1]];
  assign c_dirty    = cDirty[c_index];
  assign c_valid    = |cVal[c_index];
  assign c_tag_out  = cTag[c_index];
  assign c_data_out = cData[c_index][c_offset[2:1]];

  always @(posedge clk) begin
    if (c_enable && c_write) begin
      if (c_comp) begin
        if (c_hit) begin
          cData[c_index][c_offset[2:1]] <= c_data_in;
          cDirty[c_index] <= 1'b1;
        end
      end else begin
        cVal[c_index] <= ((cTag[c_index] != c_tag) ? 4'b0000 : cVal[c_index])
                         | (4'(c_valid_in) << c_offset[2:1]);
        cTag[c_index] <= c_tag;
        cData[c_index][c_offset[2:1]] <= c_data_in;
        cDirty[c_index] <= 1'b0;
      end
    end
  end

  // Main memory model: word-addressed, read data returns two cycles after mem_rd.
  logic [15:0] mem [32768];
  logic [15:0] rdA0, rdA1;
  assign mem_data_out = mem[rdA1[15:1]];

  logic [15:0] rdLog[$];
  logic [15:0] wrLog[$];
  logic [15:0] wrDat[$];

  always @(posedge clk) begin
    rdA1 <= rdA0;
    rdA0 <= mem_addr;
    if (mem_wr) begin
      mem[mem_addr[15:1]] <= mem_data_in;
      wrLog.push_back(mem_addr);
      wrDat.push_back(mem_data_in);
    end
    if (mem_rd) rdLog.push_back(mem_addr);
  end

  function automatic logic [15:0] initVal(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request held until Done; optional mem_stall window counted in request cycles.
  task automatic access(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic rd, input logic wr, input int stallAt, input int stallLen,
                        input int expCyc, input logic chkData, input logic [15:0] expData,
                        input logic expHit);
    int   cyc;
    logic stallOk;
    @(negedge clk);
    rdLog.delete(); wrLog.delete(); wrDat.delete();
    Addr = a; DataIn = d; Rd = rd; Wr = wr;
    cyc = 0; stallOk = 1'b1;
    mem_stall = (stallLen > 0) && (cyc >= stallAt) && (cyc < stallAt + stallLen);
    #1;
    while (Done !== 1'b1 && cyc < 60) begin
      if (Stall !== 1'b1) stallOk = 1'b0;
      @(negedge clk);
      cyc++;
      mem_stall = (stallLen > 0) && (cyc >= stallAt) && (cyc < stallAt + stallLen);
      #1;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(expCyc));
    check({tag, "_stall_before_done"}, 32'(stallOk), 32'd1);
    check({tag, "_stall_at_done"}, 32'(Stall), 32'd0);
    check({tag, "_cachehit"}, 32'(CacheHit), 32'(expHit));
    if (chkData) check({tag, "_dataout"}, 32'(DataOut), 32'(expData));
    expReq++;
    if (expHit) expHits++;
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0; mem_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; mem_stall = 1'b0;
    rdA0 = '0; rdA1 = '0;
    for (int i = 0; i < 32768; i++) mem[i] = initVal(16'(i * 2));
    mem[15'h091A] = 16'hBEEF;
    for (int i = 0; i < 32; i++) begin
      cTag[i] = '0; cVal[i] = '0; cDirty[i] = 1'b0;
      for (int w = 0; w < 4; w++) cData[i][w] = '0;
    end

    // Reset: outputs stay low even with a request present.
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h1234;
    #1;
    check("rst_done", 32'(Done), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_c_enable", 32'(c_enable), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    Rd = 1'b0; rst = 1'b0;

    // Cold read miss: clean fill of line 0x1230.
    access("cold_rd", 16'h1234, 16'h0, 1'b1, 1'b0, 0, 0, 7, 1'b1, 16'hBEEF, 1'b0);
    check("cold_rd_nrd", 32'(rdLog.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < rdLog.size()) check("cold_rd_addr", 32'(rdLog[k]), 32'(16'h1230 + 16'(2 * k)));
    check("cold_rd_nwr", 32'(wrLog.size()), 32'd0);

    // Repeat read hits with no memory traffic.
    access("hit_rd", 16'h1234, 16'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 16'hBEEF, 1'b1);
    check("hit_rd_nrd", 32'(rdLog.size()), 32'd0);

    // Store hit dirties the line, then a conflicting read forces writeback.
    access("hit_wr", 16'h1234, 16'hCAFE, 1'b0, 1'b1, 0, 0, 0, 1'b0, 16'h0, 1'b1);
    access("dirty_rd", 16'h5234, 16'h0, 1'b1, 1'b0, 0, 0, 11, 1'b1, initVal(16'h5234), 1'b0);
    check("dirty_rd_nwr", 32'(wrLog.size()), 32'd4);
    check("dirty_rd_nrd", 32'(rdLog.size()), 32'd4);
    if (wrLog.size() == 4) begin
      check("wb_addr0", 32'(wrLog[0]), 32'h1230);
      check("wb_addr3", 32'(wrLog[3]), 32'h1236);
      check("wb_data0", 32'(wrDat[0]), 32'(initVal(16'h1230)));
      check("wb_data2", 32'(wrDat[2]), 32'hCAFE);
    end
    if (rdLog.size() == 4) check("fill_addr0", 32'(rdLog[0]), 32'h5230);
    check("mem_after_wb", 32'(mem[15'h091A]), 32'hCAFE);

    // Bank stall for 3 cycles during FILL delays Done by exactly 3 cycles.
    access("stall_rd", 16'h7238, 16'h0, 1'b1, 1'b0, 2, 3, 10, 1'b1, initVal(16'h7238), 1'b0);
    access("stall_line", 16'h723C, 16'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, initVal(16'h723C), 1'b1);

    // Store miss: the filled line carries the store data.
    access("wr_miss", 16'h3456, 16'hD00D, 1'b0, 1'b1, 0, 0, 7, 1'b0, 16'h0, 1'b0);
    access("wr_miss_rd", 16'h3456, 16'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 16'hD00D, 1'b1);
    access("wr_miss_nb", 16'h3450, 16'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, initVal(16'h3450), 1'b1);

    // Reset mid-FILL after word 0 landed; the next miss must refill cleanly.
    @(negedge clk);
    Addr = 16'h9A40; Rd = 1'b1; Wr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(Stall), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_c_enable", 32'(c_enable), 32'd0);
    check("midrst_mem_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    Rd = 1'b0; rst = 1'b0;
    expReq = 0; expHits = 0;
    access("refill_rd", 16'h9A44, 16'h0, 1'b1, 1'b0, 0, 0, 7, 1'b1, initVal(16'h9A44), 1'b0);
    access("refill_w0", 16'h9A40, 16'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, initVal(16'h9A40), 1'b1);

    // Rd and Wr together: the store wins.
    access("rdwr_both", 16'h723C, 16'h1111, 1'b1, 1'b1, 0, 0, 0, 1'b0, 16'h0, 1'b1);
    access("rdwr_check", 16'h723C, 16'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 16'h1111, 1'b1);

`ifdef DCACHE_STATS_EN
    check("req_count", 32'(req_count), 32'(expReq));
    check("hit_count", 32'(hit_count), 32'(expHits));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("req_count_rst", 32'(req_count), 32'd0);
    check("hit_count_rst", 32'(hit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
